// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the LEGv8 core: operand capture,
// EX/MEM + MEM/WB forwarding, load-use bubble insertion and stall count.
module id_ex_pipe_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [63:0] id_readData1,
  input  logic [63:0] id_readData2,
  input  logic [4:0]  id_readAddr1,
  input  logic [4:0]  id_addr2,
  input  logic [4:0]  id_writeAddr,
  input  logic        id_regWrite,
  input  logic        id_memRead,
  input  logic        id_memWrite,
  input  logic        id_memToReg,
  input  logic [2:0]  id_aluOp,
  input  logic        flush,
  input  logic        exmem_regWrite,
  input  logic [4:0]  exmem_writeAddr,
  input  logic [63:0] exmem_aluResult,
  input  logic        memwb_regWrite,
  input  logic [4:0]  memwb_writeAddr,
  input  logic [63:0] memwb_writeData,
  output logic        stall,
  output logic        ex_valid,
  output logic        ex_regWrite,
  output logic        ex_memRead,
  output logic        ex_memWrite,
  output logic        ex_memToReg,
  output logic [2:0]  ex_aluOp,
  output logic [4:0]  ex_writeAddr,
  output logic [63:0] ex_opA,
  output logic [63:0] ex_opB,
  output logic [31:0] stall_count
);

  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic [2:0]  aluOp;
    logic [4:0]  writeAddr;
    logic [4:0]  srcA;
    logic [4:0]  srcB;
    logic [63:0] dataA;
    logic [63:0] dataB;
  } id_ex_t;

  localparam logic [4:0] XZR = 5'd31;

  id_ex_t      r_q;
  logic [31:0] r_stall_count;
  logic        w_hit;
  logic        w_stall;
  logic        w_bubble;

  assign w_hit = (id_readAddr1 == r_q.writeAddr)
               | (id_addr2 == r_q.writeAddr);

  assign w_stall = rst_n & ~flush & r_q.valid
                 & r_q.memRead & (r_q.writeAddr != XZR)
                 & id_valid & w_hit;

  assign w_bubble = flush | w_stall;

  // EX/MEM is younger than MEM/WB, so it wins; XZR always reads zero-path
  function automatic logic [63:0] fwd(
    input logic [4:0]  src,
    input logic [63:0] rf
  );
    if (exmem_regWrite && exmem_writeAddr == src && src != XZR)
      return exmem_aluResult;
    else if (memwb_regWrite && memwb_writeAddr == src && src != XZR)
      return memwb_writeData;
    else
      return rf;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (w_bubble) begin
      r_q.valid    <= 1'b0;
      r_q.regWrite <= 1'b0;
      r_q.memRead  <= 1'b0;
      r_q.memWrite <= 1'b0;
      r_q.memToReg <= 1'b0;
      r_q.aluOp    <= 3'd0;
    end else begin
      r_q.valid     <= id_valid;
      r_q.regWrite  <= id_valid & id_regWrite;
      r_q.memRead   <= id_valid & id_memRead;
      r_q.memWrite  <= id_valid & id_memWrite;
      r_q.memToReg  <= id_valid & id_memToReg;
      r_q.aluOp     <= id_valid ? id_aluOp : 3'd0;
      r_q.writeAddr <= id_writeAddr;
      r_q.srcA      <= id_readAddr1;
      r_q.srcB      <= id_addr2;
      r_q.dataA     <= id_readData1;
      r_q.dataB     <= id_readData2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_stall_count <= 32'd0;
    else if (w_stall && r_stall_count != 32'hFFFF_FFFF)
      r_stall_count <= r_stall_count + 32'd1;
  end

  assign stall        = w_stall;
  assign ex_valid     = r_q.valid;
  assign ex_regWrite  = r_q.regWrite;
  assign ex_memRead   = r_q.memRead;
  assign ex_memWrite  = r_q.memWrite;
  assign ex_memToReg  = r_q.memToReg;
  assign ex_aluOp     = r_q.aluOp;
  assign ex_writeAddr = r_q.writeAddr;
  assign ex_opA       = fwd(r_q.srcA, r_q.dataA);
  assign ex_opB       = fwd(r_q.srcB, r_q.dataB);
  assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed steps plus a random phase
// checked against an abstract model of the ID/EX slot.
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [63:0] id_readData1, id_readData2;
  logic [4:0]  id_readAddr1, id_addr2, id_writeAddr;
  logic        id_regWrite, id_memRead, id_memWrite, id_memToReg;
  logic [2:0]  id_aluOp;
  logic        flush;
  logic        exmem_regWrite;
  logic [4:0]  exmem_writeAddr;
  logic [63:0] exmem_aluResult;
  logic        memwb_regWrite;
  logic [4:0]  memwb_writeAddr;
  logic [63:0] memwb_writeData;
  logic        stall, ex_valid;
  logic        ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg;
  logic [2:0]  ex_aluOp;
  logic [4:0]  ex_writeAddr;
  logic [63:0] ex_opA, ex_opB;
  logic [31:0] stall_count;

  int total = 0;
  int bad = 0;

  // model of what the EX slot should hold
  logic        m_v, m_rw, m_mr, m_mw, m_m2r;
  logic [2:0]  m_op;
  logic [4:0]  m_wa, m_sa, m_sb;
  logic [63:0] m_a, m_b;
  logic [31:0] m_cnt;
  logic        m_known, m_opk;
  logic        m_last_stall;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_readData1(id_readData1), .id_readData2(id_readData2),
    .id_readAddr1(id_readAddr1), .id_addr2(id_addr2),
    .id_writeAddr(id_writeAddr), .id_regWrite(id_regWrite),
    .id_memRead(id_memRead), .id_memWrite(id_memWrite),
    .id_memToReg(id_memToReg), .id_aluOp(id_aluOp),
    .flush(flush),
    .exmem_regWrite(exmem_regWrite),
    .exmem_writeAddr(exmem_writeAddr),
    .exmem_aluResult(exmem_aluResult),
    .memwb_regWrite(memwb_regWrite),
    .memwb_writeAddr(memwb_writeAddr),
    .memwb_writeData(memwb_writeData),
    .stall(stall), .ex_valid(ex_valid),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .ex_memWrite(ex_memWrite), .ex_memToReg(ex_memToReg),
    .ex_aluOp(ex_aluOp), .ex_writeAddr(ex_writeAddr),
    .ex_opA(ex_opA), .ex_opB(ex_opB),
    .stall_count(stall_count)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] t;
    case ($urandom_range(0, 4))
      0: t = 5'd3;
      1: t = 5'd5;
      2: t = 5'd7;
      3: t = 5'd31;
      default: t = 5'($urandom);
    endcase
    return t;
  endfunction

  function automatic logic [63:0] r64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  task automatic rnd_id();
    id_valid     = 1'($urandom);
    id_readData1 = r64();
    id_readData2 = r64();
    id_readAddr1 = pick_reg();
    id_addr2     = pick_reg();
    id_writeAddr = pick_reg();
    id_regWrite  = 1'($urandom);
    id_memRead   = 1'($urandom);
    id_memWrite  = 1'($urandom);
    id_memToReg  = 1'($urandom);
    id_aluOp     = 3'($urandom);
  endtask

  task automatic rnd_fwd();
    exmem_regWrite  = 1'($urandom);
    exmem_writeAddr = pick_reg();
    exmem_aluResult = r64();
    memwb_regWrite  = 1'($urandom);
    memwb_writeAddr = pick_reg();
    memwb_writeData = r64();
  endtask

  task automatic idle();
    rst_n = 1'b1; flush = 1'b0;
    id_valid = 1'b0;
    id_readData1 = '0; id_readData2 = '0;
    id_readAddr1 = 5'd0; id_addr2 = 5'd0;
    id_writeAddr = 5'd0;
    id_regWrite = 1'b0; id_memRead = 1'b0;
    id_memWrite = 1'b0; id_memToReg = 1'b0;
    id_aluOp = 3'd0;
    exmem_regWrite = 1'b0; exmem_writeAddr = 5'd0;
    exmem_aluResult = '0;
    memwb_regWrite = 1'b0; memwb_writeAddr = 5'd0;
    memwb_writeData = '0;
  endtask

  task automatic set_id(input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] wa,
                        input logic [63:0] da, input logic [63:0] db,
                        input logic load);
    id_valid = 1'b1;
    id_readAddr1 = ra; id_addr2 = rb; id_writeAddr = wa;
    id_readData1 = da; id_readData2 = db;
    id_regWrite = 1'b1; id_memRead = load;
    id_memWrite = 1'b0; id_memToReg = load;
    id_aluOp = 3'd2;
  endtask

  function automatic logic exp_stall();
    return rst_n && !flush && m_v && m_mr && m_wa != 5'd31
        && id_valid
        && (id_readAddr1 == m_wa || id_addr2 == m_wa);
  endfunction

  function automatic logic [63:0] exp_op(input logic [4:0] s,
                                         input logic [63:0] d);
    if (s == 5'd31) return d;
    if (exmem_regWrite && exmem_writeAddr == s) return exmem_aluResult;
    if (memwb_regWrite && memwb_writeAddr == s) return memwb_writeData;
    return d;
  endfunction

  task automatic mdl_update(input logic st);
    if (!rst_n) begin
      {m_v, m_rw, m_mr, m_mw, m_m2r} = '0;
      m_op = '0; m_wa = '0; m_sa = '0; m_sb = '0;
      m_a = '0; m_b = '0; m_cnt = '0;
      m_known = 1'b1; m_opk = 1'b1;
    end else if (flush || st) begin
      {m_v, m_rw, m_mr, m_mw, m_m2r} = '0;
      m_op = '0; m_opk = 1'b1; m_known = 1'b0;
    end else begin
      m_v = id_valid;
      m_rw = id_valid & id_regWrite;
      m_mr = id_valid & id_memRead;
      m_mw = id_valid & id_memWrite;
      m_m2r = id_valid & id_memToReg;
      m_op = id_aluOp; m_opk = id_valid;
      m_wa = id_writeAddr; m_sa = id_readAddr1; m_sb = id_addr2;
      m_a = id_readData1; m_b = id_readData2;
      m_known = 1'b1;
    end
    if (rst_n && st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
  endtask

  // compare everything, then take one clock edge through the model
  task automatic cyc();
    logic st;
    st = exp_stall();
    chk("stall", 64'(stall), 64'(st));
    chk("ex_valid", 64'(ex_valid), 64'(m_v));
    chk("ex_ctrl", 64'({ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg}),
        64'({m_rw, m_mr, m_mw, m_m2r}));
    chk("stall_count", 64'(stall_count), 64'(m_cnt));
    if (m_opk) chk("ex_aluOp", 64'(ex_aluOp), 64'(m_op));
    if (m_known) begin
      chk("ex_writeAddr", 64'(ex_writeAddr), 64'(m_wa));
      chk("ex_opA", ex_opA, exp_op(m_sa, m_a));
      chk("ex_opB", ex_opB, exp_op(m_sb, m_b));
    end
    m_last_stall = st;
    @(posedge clk);
    mdl_update(st);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] c0;
    idle();
    rst_n = 1'b0;
    rnd_id(); rnd_fwd();
    id_valid = 1'b1;
    @(posedge clk);
    mdl_update(1'b0);
    @(negedge clk);

    // reset held for a second cycle with random ID traffic
    rnd_id(); id_valid = 1'b1;
    exmem_regWrite = 1'b0; memwb_regWrite = 1'b0;
    #1;
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_opA", ex_opA, 64'd0);
    chk("rst_opB", ex_opB, 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_cnt", 64'(stall_count), 64'd0);
    chk("rst_wa", 64'(ex_writeAddr), 64'd0);
    cyc();

    // plain pass
    idle();
    set_id(5'd1, 5'd2, 5'd5, 64'h11, 64'h22, 1'b0);
    id_aluOp = 3'd3;
    cyc();
    idle();
    #1;
    chk("pass_opA", ex_opA, 64'h11);
    chk("pass_opB", ex_opB, 64'h22);
    chk("pass_wa", 64'(ex_writeAddr), 64'd5);
    chk("pass_rw", 64'(ex_regWrite), 64'd1);
    chk("pass_valid", 64'(ex_valid), 64'd1);
    chk("pass_op", 64'(ex_aluOp), 64'd3);
    cyc();

    // load-use: LDUR X3 then a reader of X3 via addr2
    set_id(5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 1'b1);
    cyc();
    set_id(5'd4, 5'd3, 5'd6, 64'h44, 64'h999, 1'b0);
    #1;
    chk("lu_stall", 64'(stall), 64'd1);
    cyc();
    #1;
    chk("lu_stall2", 64'(stall), 64'd0);
    chk("lu_bubble", 64'(ex_valid), 64'd0);
    chk("lu_cnt", 64'(stall_count), 64'd1);
    cyc();
    idle();
    exmem_regWrite = 1'b1; exmem_writeAddr = 5'd3;
    exmem_aluResult = 64'hABCD;
    memwb_regWrite = 1'b1; memwb_writeAddr = 5'd3;
    memwb_writeData = 64'hABCD;
    #1;
    chk("lu_opB", ex_opB, 64'hABCD);
    chk("lu_valid", 64'(ex_valid), 64'd1);
    cyc();

    // forward priority
    idle();
    set_id(5'd7, 5'd8, 5'd9, 64'h77, 64'h88, 1'b0);
    cyc();
    idle();
    exmem_regWrite = 1'b1; exmem_writeAddr = 5'd7;
    exmem_aluResult = 64'hAA;
    memwb_regWrite = 1'b1; memwb_writeAddr = 5'd7;
    memwb_writeData = 64'hBB;
    #1;
    chk("fw_exmem", ex_opA, 64'hAA);
    exmem_regWrite = 1'b0;
    #1;
    chk("fw_memwb", ex_opA, 64'hBB);
    cyc();
    idle();
    set_id(5'd31, 5'd8, 5'd9, 64'h3131, 64'h88, 1'b0);
    cyc();
    idle();
    exmem_regWrite = 1'b1; exmem_writeAddr = 5'd31;
    exmem_aluResult = 64'hAA;
    memwb_regWrite = 1'b1; memwb_writeAddr = 5'd31;
    memwb_writeData = 64'hBB;
    #1;
    chk("fw_xzr", ex_opA, 64'h3131);
    cyc();

    // flush beats a load-use hazard
    idle();
    set_id(5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 1'b1);
    cyc();
    set_id(5'd3, 5'd2, 5'd6, 64'h5, 64'h6, 1'b0);
    flush = 1'b1;
    c0 = stall_count;
    #1;
    chk("fl_stall", 64'(stall), 64'd0);
    cyc();
    idle();
    #1;
    chk("fl_valid", 64'(ex_valid), 64'd0);
    chk("fl_cnt", 64'(stall_count), 64'(c0));
    cyc();

    // load to X31 never stalls
    set_id(5'd1, 5'd2, 5'd31, 64'h1, 64'h2, 1'b1);
    cyc();
    set_id(5'd31, 5'd31, 5'd6, 64'h5, 64'h6, 1'b0);
    #1;
    chk("xzr_nostall", 64'(stall), 64'd0);
    cyc();

    // counter saturation
    idle();
    set_id(5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 1'b1);
    cyc();
    set_id(5'd3, 5'd0, 5'd3, 64'h5, 64'h6, 1'b1);
    force dut.r_stall_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_count;
    m_cnt = 32'hFFFF_FFFE;
    cyc();
    #1;
    chk("sat_ff", 64'(stall_count), 64'hFFFF_FFFF);
    cyc();
    set_id(5'd3, 5'd9, 5'd10, 64'h7, 64'h8, 1'b0);
    #1;
    chk("sat_stall", 64'(stall), 64'd1);
    cyc();
    #1;
    chk("sat_hold", 64'(stall_count), 64'hFFFF_FFFF);
    cyc();

    // random traffic; upstream holds ID while stalled
    idle();
    m_last_stall = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!m_last_stall) rnd_id();
      rnd_fwd();
      flush = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 59) != 0);
      #1;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
